// File: rtl/sudoku_pkg.sv
// Shared types for the sudoku sequencer: controller states, result codes, grid sizes
// and the BCD-digit to one-hot cell encoding used by the solver's input buffer.
package sudoku_pkg;

  localparam int CELLS   = 81;
  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, START, RUN, DRAIN} state_t;

  typedef enum logic [1:0] {RES_NONE, RES_SOLVED, RES_FAIL, RES_STUCK} result_t;

  // Digits 1..9 map to bit d-1; blank (0) and the non-BCD codes 10..15 map to no candidate.
  function automatic logic [8:0] digit_to_onehot(input logic [DIGIT_W-1:0] d);
    logic [8:0] oh;
    oh = '0;
    if (d >= 4'd1 && d <= 4'd9) oh[d - 4'd1] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/sudoku_sequencer_progress_monitor.sv
// Watches the solver grid while it runs: flags a fully solved grid, and a stuck one when the
// grid stops changing for STALL_LIMIT cycles or the run reaches TIMEOUT cycles.
module progress_monitor
  import sudoku_pkg::*;
#(
  parameter int STALL_LIMIT = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic                          clock,
  input  logic                          reset_L,
  input  logic                          clear,
  input  logic                          run,
  input  logic [8:0][8:0][DIGIT_W-1:0]  hr_vals,
  output logic                          solved,
  output logic                          stuck
);

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  localparam int RUN_W   = $clog2(TIMEOUT + 1);

  logic [8:0][8:0][DIGIT_W-1:0] snapshot;
  logic [STALL_W-1:0]           stall_cnt;
  logic [STALL_W-1:0]           stall_nxt;
  logic [RUN_W-1:0]             run_cnt;
  logic [RUN_W-1:0]             run_nxt;

  // Limits compare against the post-increment counts so the verdict lands in the
  // cycle that completes the limit, not one cycle later.
  always_comb begin
    solved = 1'b1;
    for (int r = 0; r < 9; r++) begin
      for (int c = 0; c < 9; c++) begin
        if (hr_vals[r][c] == '0) solved = 1'b0;
      end
    end

    stall_nxt = '0;
    if (hr_vals == snapshot) begin
      stall_nxt = (stall_cnt == STALL_W'(STALL_LIMIT)) ? stall_cnt : stall_cnt + 1'b1;
    end

    run_nxt = (run_cnt == RUN_W'(TIMEOUT)) ? run_cnt : run_cnt + 1'b1;

    stuck = (stall_nxt == STALL_W'(STALL_LIMIT)) || (run_nxt == RUN_W'(TIMEOUT));
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      snapshot  <= '0;
      stall_cnt <= '0;
      run_cnt   <= '0;
    end else if (clear) begin
      snapshot  <= '0;
      stall_cnt <= '0;
      run_cnt   <= '0;
    end else if (run) begin
      snapshot  <= hr_vals;
      stall_cnt <= stall_nxt;
      run_cnt   <= run_nxt;
    end
  end

endmodule

// File: rtl/sudoku_sequencer.sv
// Puzzle lifecycle controller for one solver: clear, load 81 digits, start, watch for a verdict,
// then drain the 81 result digits with valid/ready backpressure.
module sudoku_sequencer
  import sudoku_pkg::*;
#(
  parameter int STALL_LIMIT = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic                          clock,
  input  logic                          reset_L,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DIGIT_W-1:0]            in_data,
  output logic                          cell_we,
  output logic [6:0]                    cell_addr,
  output logic [8:0]                    cell_onehot,
  output logic                          solver_reset_L,
  output logic                          solve_start,
  input  logic                          solver_fail,
  input  logic [8:0][8:0][DIGIT_W-1:0]  hr_vals,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DIGIT_W-1:0]            out_data,
  output logic                          out_last,
  output logic                          busy,
  output logic [1:0]                    result,
  output logic                          done
);

  localparam logic [6:0] LAST_CELL = 7'(CELLS - 1);

  state_t     state;
  result_t    res;
  logic [6:0] load_idx;
  logic [6:0] out_idx;
  logic [3:0] out_row;
  logic [3:0] out_col;
  logic       solved;
  logic       stuck;

  assign in_ready    = (state == LOAD);
  assign cell_we     = in_ready && in_valid;
  assign cell_addr   = load_idx;
  assign cell_onehot = cell_we ? digit_to_onehot(in_data) : 9'd0;

  // Row/column are tracked alongside the linear index to avoid a divide-by-9 on the read path.
  assign out_data = out_valid ? hr_vals[out_row][out_col] : '0;
  assign out_last = out_valid && (out_idx == LAST_CELL);
  assign busy     = (state != IDLE);
  assign result   = res;

  progress_monitor #(
    .STALL_LIMIT (STALL_LIMIT),
    .TIMEOUT     (TIMEOUT)
  ) u_monitor (
    .clock   (clock),
    .reset_L (reset_L),
    .clear   (state == START),
    .run     (state == RUN),
    .hr_vals (hr_vals),
    .solved  (solved),
    .stuck   (stuck)
  );

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state          <= IDLE;
      res            <= RES_NONE;
      load_idx       <= '0;
      out_idx        <= '0;
      out_row        <= '0;
      out_col        <= '0;
      solver_reset_L <= 1'b0;
      solve_start    <= 1'b0;
      out_valid      <= 1'b0;
      done           <= 1'b0;
    end else begin
      solver_reset_L <= 1'b1;
      solve_start    <= 1'b0;
      done           <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state          <= CLEAR;
            solver_reset_L <= 1'b0;
          end
        end
        CLEAR: begin
          state    <= LOAD;
          res      <= RES_NONE;
          load_idx <= '0;
        end
        LOAD: begin
          if (cell_we) begin
            if (load_idx == LAST_CELL) begin
              load_idx    <= '0;
              state       <= START;
              solve_start <= 1'b1;
            end else begin
              load_idx <= load_idx + 7'd1;
            end
          end
        end
        START: begin
          state <= RUN;
        end
        RUN: begin
          // Contradiction outranks a full grid, which outranks the stall/timeout verdict.
          if (solver_fail) begin
            res       <= RES_FAIL;
            state     <= DRAIN;
            out_valid <= 1'b1;
          end else if (solved) begin
            res       <= RES_SOLVED;
            state     <= DRAIN;
            out_valid <= 1'b1;
          end else if (stuck) begin
            res       <= RES_STUCK;
            state     <= DRAIN;
            out_valid <= 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_idx == LAST_CELL) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              done      <= 1'b1;
              out_idx   <= '0;
              out_row   <= '0;
              out_col   <= '0;
            end else begin
              out_idx <= out_idx + 7'd1;
              if (out_col == 4'd8) begin
                out_col <= '0;
                out_row <= out_row + 4'd1;
              end else begin
                out_col <= out_col + 4'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sudoku_sequencer.md
# sudoku_sequencer

Controller that owns one `solver` instance for a full puzzle lifecycle:
- clears the solver, streams 81 input digits into the cell buffer and pulses the solver's start;
- watches the grid for solved, fail, stall or timeout;
- streams the 81 resulting digits out with valid/ready backpressure.

It sits between the host-side transfer logic and the solver, and replaces the separate input and output transfer FSMs.

## Interface
Parameters:
- STALL_LIMIT, 4, consecutive unchanged RUN cycles that declare the puzzle stuck
- TIMEOUT, 1023, maximum RUN cycles before declaring stuck

Ports:
- clock  in  1  single clock
- reset_L  in  1  asynchronous, active-low reset
- in_valid  in  1  input digit valid
- in_ready  out  1  sequencer accepts an input digit
- in_data  in  4  BCD digit, 0 = blank, row-major order
- cell_we  out  1  write strobe to the cell input buffer
- cell_addr  out  7  cell index 0..80 (9*row+col)
- cell_onehot  out  9  one-hot of in_data (bit d-1 for digit d)
- solver_reset_L  out  1  registered active-low clear for the solver
- solve_start  out  1  one-cycle pulse to the solver's start
- solver_fail  in  1  solver contradiction flag
- hr_vals  in  81x4 ([8:0][8:0][3:0])  solver digits, hr_vals[r][c]
- out_valid  out  1  output digit valid
- out_ready  in  1  downstream accepts
- out_data  out  4  digit, row-major order
- out_last  out  1  high with cell 80
- busy  out  1  state is not IDLE
- result  out  2  0 NONE, 1 SOLVED, 2 FAIL, 3 STUCK
- done  out  1  one-cycle pulse after the last output beat

## Operation
States and transitions:
- IDLE: in_ready=0. in_valid=1 → CLEAR. No data is consumed in IDLE.
- CLEAR: one cycle. solver_reset_L=0, result←NONE. → LOAD.
- LOAD: in_ready=1. Each handshake drives cell_we=1, cell_addr=load count, cell_onehot=decode(in_data). All three are combinational from the handshake. in_data 0 or 10..15 gives onehot 0. The 81st beat → START.
- START: one cycle. solve_start=1. Clears the snapshot (all zero), the stall count and the run count. → RUN.
- RUN: each cycle, in priority order:
  - solver_fail → result FAIL.
  - Else all 81 hr_vals nonzero → result SOLVED.
  - Else stall count reaches STALL_LIMIT, or run count reaches TIMEOUT → result STUCK.
  - Any of the above → DRAIN.
  - Each cycle the snapshot ← hr_vals. The stall count increments when hr_vals equals the snapshot and clears otherwise. The run count increments every cycle.
- DRAIN: out_valid=1, out_data=hr_vals[r][c] at out index, out_last at index 80.
  - The index advances on out_valid&&out_ready.
  - The last handshake → IDLE with a done pulse.
  - The grid is drained regardless of result; unresolved cells read 0.

Rules:
- result holds until the next CLEAR.
- in_valid is ignored outside LOAD.

## Timing
- Reset values: in_ready 0, cell_we 0, cell_addr 0, cell_onehot 0, solver_reset_L 0, solve_start 0, out_valid 0, out_data 0, out_last 0, busy 0, result NONE, done 0, state IDLE, all counters 0.
- After reset deasserts, solver_reset_L is 1 from the first clock.
- solver_reset_L, solve_start and done are registered. This keeps them glitch-free.
- Cell writes land at the handshake edge. The last write therefore lands before START, and the solver loads all 81 cells at the end of START.
- The RUN decision is made combinationally. result, state and out_valid update at the following edge.
- DRAIN output ordering:
  - The first out_valid appears in the cycle after the deciding RUN cycle.
  - While out_valid=1 and out_ready=0, out_data and out_last hold.
  - With out_ready held high, there is one beat per cycle, 81 cycles in total.
- Reset mid-operation asynchronously returns to IDLE with reset values. A load restarts at cell 0.
- Counter widths:
  - load and out index: 7 bits.
  - stall count: $clog2(STALL_LIMIT+1).
  - run count: $clog2(TIMEOUT+1), saturating.

## Structure
- Shared `sudoku_pkg` holds:
  - state enum {IDLE, CLEAR, LOAD, START, RUN, DRAIN};
  - result enum;
  - CELLS=81, DIGIT_W=4;
  - function digit_to_onehot.
- Sub-module `progress_monitor`: snapshot register, equality compare, stall/run counters and the solved/stuck flags. Cleared by START.

## Test plan
- Reset: assert reset_L=0 mid-LOAD at cell 40. All outputs go to reset values. The next load writes cell_addr from 0.
- Easy puzzle (singles only), with the real solver and out_ready=1:
  - solve_start pulses once after the 81st beat;
  - result=SOLVED;
  - 81 beats match the reference solution;
  - out_last is on beat 81, done is one cycle later.
- Conflicting puzzle (two 5s in row 0) → solver_fail → result=FAIL, and the drain outputs 81 beats.
- Blank puzzle, STALL_LIMIT=4: START at cycle t, RUN t+1..t+4, DRAIN at t+5, result=STUCK, 81 zeros drained.
- Random out_ready at 50%: no dropped or duplicated beats, and out_data is stable while stalled.
- Decode check:
  - in_data=12 gives cell_onehot=0;
  - in_data=9 gives 9'b100000000;
  - in_valid pulsed during DRAIN is not consumed (in_ready=0).
